// File: rtl/cp0_pkg.sv
// cp0_pkg: register indices, SR/Cause field positions and exception codes
// shared by the cp0_ext coprocessor and its timer.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_TI_BIT = 30;
  localparam int CAUSE_BD_BIT = 31;

  // Width of the IM/IP fields; external lines and the timer share them.
  localparam int N_IRQ_LINES  = 6;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // Address-error exceptions are the only ones that latch BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-interrupt flag.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_inc;

  assign count_inc = count + 32'd1;

  // Count increments (wrapping) unless software loads it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (we_count) begin
      count <= din;
    end else begin
      count <= count_inc;
    end
  end

  // Compare only changes on an mtc0 write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      compare <= '0;
    end else if (we_compare) begin
      compare <= din;
    end
  end

  // TI sets when the incremented count reaches Compare; a Compare write
  // acknowledges it and takes precedence over a coincident match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ti <= 1'b0;
    end else if (we_compare) begin
      ti <= 1'b0;
    end else if (!we_count && (count_inc == compare)) begin
      ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_ext.sv
// cp0_ext: system-control coprocessor (SR, Cause, EPC, PrID, BadVAddr and an
// optional Count/Compare timer) attached at the M stage.
// Build option: define CP0_TIMER_EN to include the Count/Compare timer;
// without it indices 9 and 11 read 0 and the timer interrupt is tied off.
module cp0_ext
  import cp0_pkg::*;
#(
  parameter int          N_HWINT    = 6,
  parameter int          TIMER_LINE = 5,
  parameter logic [31:0] PRID       = 32'h1CC0_0001
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               WE,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIn,
  output logic [31:0]        DOut,
  input  logic               BDIn,
  input  logic [31:0]        VPC,
  input  logic [4:0]         ExcCodeIn,
  input  logic [31:0]        BadVAddrIn,
  input  logic [N_HWINT-1:0] HWInt,
  input  logic               EXLClr,
  output logic               Req,
  output logic [31:0]        EPCOut,
  output logic               TimerIrq
);

  if (N_HWINT < 1 || N_HWINT > N_IRQ_LINES) begin : g_bad_hwint
    $error("cp0_ext: N_HWINT must be 1..6");
  end
  if (TIMER_LINE < 0 || TIMER_LINE > N_IRQ_LINES - 1) begin : g_bad_timer_line
    $error("cp0_ext: TIMER_LINE must be 0..5");
  end

  logic [N_IRQ_LINES-1:0] sr_im;
  logic                   sr_exl;
  logic                   sr_ie;
  logic                   cause_bd;
  logic [N_IRQ_LINES-1:0] cause_ip;
  logic [4:0]             cause_exc;
  logic [31:0]            epc;
  logic [31:0]            bad_vaddr;

  logic [N_IRQ_LINES-1:0] hw_ext;
  logic [N_IRQ_LINES-1:0] pend;
  logic                   ti;
  logic                   int_req;
  logic                   exc_req;
  logic                   req;
  logic                   we_sr;
  logic                   we_epc;
  logic [31:0]            sr_word;
  logic [31:0]            cause_word;

  assign we_sr  = WE && (A2 == REG_SR);
  assign we_epc = WE && (A2 == REG_EPC);

  // Zero-extend the external lines onto the 6-bit IP field.
  always_comb begin
    hw_ext              = '0;
    hw_ext[N_HWINT-1:0] = HWInt;
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;

  cp0_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .we_count   (WE && (A2 == REG_COUNT)),
    .we_compare (WE && (A2 == REG_COMPARE)),
    .din        (DIn),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  assign pend = hw_ext | (N_IRQ_LINES'(ti) << TIMER_LINE);
`else
  assign ti   = 1'b0;
  assign pend = hw_ext;
`endif

  assign int_req = |(pend & sr_im) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
  // Gated by reset so the pipeline sees no request while the block is held.
  assign req     = reset_n & (int_req | exc_req);

  assign Req      = req;
  assign EPCOut   = epc;
  assign TimerIrq = ti;

  // SR: software write first, then eret clear, then exception entry forces EXL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im  <= '0;
      sr_exl <= 1'b0;
      sr_ie  <= 1'b0;
    end else begin
      if (we_sr) begin
        sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
        sr_exl <= DIn[SR_EXL_BIT];
        sr_ie  <= DIn[SR_IE_BIT];
      end else if (EXLClr) begin
        sr_exl <= 1'b0;
      end
      if (req) begin
        sr_exl <= 1'b1;
      end
    end
  end

  // Cause: IP tracks pending lines every cycle; BD/ExcCode latch on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_ip  <= '0;
      cause_bd  <= 1'b0;
      cause_exc <= '0;
    end else begin
      cause_ip <= pend;
      if (req) begin
        cause_bd  <= BDIn;
        cause_exc <= int_req ? EXC_INT : ExcCodeIn;
      end
    end
  end

  // EPC: exception entry beats a software write in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epc <= '0;
    end else if (req) begin
      epc <= BDIn ? (VPC - 32'd4) : VPC;
    end else if (we_epc) begin
      epc <= DIn;
    end
  end

  // BadVAddr: only an address error that actually wins the request latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bad_vaddr <= '0;
    end else if (req && !int_req && is_addr_exc(ExcCodeIn)) begin
      bad_vaddr <= BadVAddrIn;
    end
  end

  // Assemble SR and Cause read words with unimplemented bits at 0.
  always_comb begin
    sr_word                        = '0;
    sr_word[SR_IM_HI:SR_IM_LO]     = sr_im;
    sr_word[SR_EXL_BIT]            = sr_exl;
    sr_word[SR_IE_BIT]             = sr_ie;
    cause_word                     = '0;
    cause_word[CAUSE_BD_BIT]       = cause_bd;
    cause_word[CAUSE_TI_BIT]       = ti;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
  end

  // mfc0 read mux; no bypass of a same-cycle write.
  always_comb begin
    DOut = '0;
    case (A1)
      REG_BADVADDR: DOut = bad_vaddr;
`ifdef CP0_TIMER_EN
      REG_COUNT:    DOut = count;
      REG_COMPARE:  DOut = compare;
`endif
      REG_SR:       DOut = sr_word;
      REG_CAUSE:    DOut = cause_word;
      REG_EPC:      DOut = epc;
      REG_PRID:     DOut = PRID;
      default:      DOut = '0;
    endcase
  end

endmodule

// File: doc/cp0_ext.md
# cp0_ext

Parametrised system-control coprocessor for the pipelined MIPS core. It is a successor to the existing CP0 and keeps its SR/Cause/EPC/PrID semantics and its M-stage attachment point. It adds:
- a configurable hardware-interrupt width;
- a BadVAddr register captured on address exceptions;
- a Count/Compare timer that raises its own interrupt.

The pipeline samples Req in M and redirects fetch to the handler. `eret` asserts EXLClr and returns through EPCOut.

## Interface
Parameters:
- N_HWINT, 6: number of external interrupt lines. Legal range 1..6. Lines map to IM/IP bits 10..(10+N_HWINT-1).
- TIMER_LINE, 5: IP bit index (0..5) that the timer interrupt is OR'd onto.
- PRID, 32'h1CC0_0001: reset and constant value of PrID.

Ports:
- clk  in  1  single clock. All state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- WE  in  1  mtc0 write enable.
- A1  in  5  mfc0 read register index.
- A2  in  5  mtc0 write register index.
- DIn  in  32  mtc0 write data.
- DOut  out  32  mfc0 read data. Combinational.
- BDIn  in  1  faulting instruction sits in a delay slot.
- VPC  in  32  PC of the M-stage instruction.
- ExcCodeIn  in  5  exception code from the pipeline. 0 means none.
- BadVAddrIn  in  32  faulting address. Valid when ExcCodeIn is 4 or 5.
- HWInt  in  N_HWINT  external interrupt requests. Level-sensitive.
- EXLClr  in  1  eret in M.
- Req  out  1  take exception or interrupt this cycle. Combinational.
- EPCOut  out  32  current EPC.
- TimerIrq  out  1  registered timer-interrupt flag (TI).

## Operation
- Register map:
  - 8: BadVAddr, read-only.
  - 9: Count, read/write.
  - 11: Compare, read/write.
  - 12: SR.
  - 13: Cause (read-only to software).
  - 14: EPC.
  - 15: PrID, read-only.
  - Other indices read 0 and ignore writes.
- SR fields: IM = [15:10], EXL = [1], IE = [0]. Unimplemented bits read 0.
- Cause fields: BD = [31], TI = [30], IP = [15:10], ExcCode = [6:2]. Unimplemented bits read 0.
- Pending vector P = zero-extended HWInt, OR'd with TI on bit TIMER_LINE.
- IntReq = |(P & IM) & IE & ~EXL.
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq. Interrupt has priority over exception.
- On Req, at the clock edge:
  - EPC <= VPC - (BDIn ? 4 : 0).
  - BD <= BDIn.
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - If ExcReq wins and ExcCodeIn is 4 or 5, BadVAddr <= BadVAddrIn.
- IP <= P every cycle.
- EXLClr clears EXL.
- mtc0 writes: SR writes IM/EXL/IE only. EPC writes the full 32 bits. Writes to Cause, PrID and BadVAddr are ignored.
- Timer:
  - Count increments by 1 every cycle and wraps 0xFFFF_FFFF to 0.
  - When the next Count value equals Compare, TI <= 1. TI is sticky.
  - An mtc0 write to Compare loads Compare and clears TI.
  - An mtc0 write to Count loads DIn in place of the increment. No match is evaluated in that cycle.

## Timing
- Reset (async assert, sync-to-clk deassert use): all registers 0 except PrID = PRID.
  - Reset outputs: Req=0, DOut=0 for index 0, EPCOut=0, TimerIrq=0.
- DOut, Req and EPCOut are combinational from current state and inputs, with zero latency.
- An mtc0 write is visible to mfc0 on the next cycle. There is no read-during-write bypass.
- Simultaneous events:
  - Req and mtc0 SR in the same cycle: the write is applied first, then EXL is forced to 1.
  - Req and mtc0 EPC: Req wins.
  - EXLClr and mtc0 SR with EXL=1: the write wins.
  - Req and EXLClr cannot coincide usefully, since Req needs EXL=0. If both assert, EXL ends at 1.
  - Compare write and match in the same cycle: TI ends at 0.
- HWInt-to-Req latency is 0 cycles once IM, IE and ~EXL are set. Cause.IP lags HWInt by 1 cycle.
- Compare = C, Count = C-1 at edge k: TI=1 after edge k; Req (if enabled) asserts in cycle k+1.
- Reset asserted mid-exception: state clears immediately and asynchronously. Req drops combinationally.

## Configuration
- CP0_TIMER_EN defined:
  - Count, Compare, TI and TimerIrq are implemented as described.
- CP0_TIMER_EN undefined:
  - Indices 9 and 11 read 0 and ignore writes.
  - TI and TimerIrq are tied to 0.
  - TIMER_LINE is unused.
  - P is HWInt only.

## Structure
- Shared package cp0_pkg:
  - Register-index constants (8, 9, 11..15).
  - SR and Cause field bit positions.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
- Sub-module cp0_timer holds Count, Compare and TI.
  - Inputs: write strobes and DIn.
  - Outputs: Count, Compare, TI.
  - Instantiated only under CP0_TIMER_EN.

## Test plan
- Reset, then mfc0 15 -> DOut=PRID. mfc0 12/13/14 -> 0. Req=0.
- mtc0 12 = 0x0000_0401, HWInt[0]=1, VPC=0x3000, BDIn=1 -> Req=1 that cycle. Next cycle: EPC=0x2FFC, Cause.BD=1, ExcCode=0, EXL=1, Req=0.
- ExcCodeIn=4, BadVAddrIn=0x1235, VPC=0x3010, BDIn=0 -> BadVAddr=0x1235, ExcCode=4, EPC=0x3010. A following ExcCodeIn=12 with EXL=1 -> Req=0, no state change.
- Timer: Compare=20, Count=15, IM bit TIMER_LINE and IE set -> TimerIrq rises after 5 edges, then Req. mtc0 Compare clears TI and Req.
- Count=0xFFFF_FFFF, Compare=0 -> wrap to 0 sets TI. mtc0 Count in the same cycle as a would-be match -> TI stays 0.
- Simultaneous Req and mtc0 12 = 0x0 -> SR.EXL=1 afterwards. Then EXLClr -> EXL=0, and a still-pending HWInt stays masked because IE=0.
